// File: rtl/phase_readout_pkg.sv
// Shared constants for the phase readout block: sampler address map and
// readout FSM state encodings.
package phase_readout_pkg;

    // Sampler read port address map: counter i lives at base + stride*i.
    localparam logic [31:0] PHASE_ADDR_BASE = 32'h0000_0100;
    localparam logic [31:0] ADDR_STRIDE     = 32'd4;

    // Readout FSM state encodings.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_SWEEP = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Sampler read address of phase counter number 'index'.
    function automatic logic [31:0] sweep_addr(input logic [31:0] index);
        return PHASE_ADDR_BASE + ADDR_STRIDE * index;
    endfunction

endpackage

// File: rtl/phase_readout_window_timer.sv
// Loadable W-bit down-counter timing the sampler integration window.
// 'expire' is high while the count sits at 1, i.e. during the last cycle of
// the window, so the owner can leave the window on that edge.
module window_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] count;

    // Load takes priority; otherwise count down while enabled, holding at 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == W'(1));

endmodule

// File: rtl/phase_readout.sv
// Phase readout controller: clears the phase sampler, lets it integrate for
// a programmed window, sweeps its read port over all N counters, thresholds
// each count into a spin bit and publishes the packed spin vector.
// All outputs are registered from the next-state decision, so each output
// already reflects the state being entered on the same edge.
module phase_readout
    import phase_readout_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] sample_cycles,
    input  logic [W-1:0] threshold,
    output logic         sample_rstn,
    output logic [31:0]  rd_addr,
    input  logic [W-1:0] phase,
    output logic [N-1:0] spins,
    output logic         result_valid,
    output logic         busy,
    output logic         done
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [2:0]       state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [W-1:0]     cycles_q, thresh_q;
    logic [N-1:0]     shadow_q, shadow_next;
    logic             start_ok;
    logic             last_capture;
    logic             window_expire;

    assign start_ok     = (state == ST_IDLE) && start && !abort;
    assign last_capture = (state == ST_SWEEP) && (idx == LAST_IDX) && !abort;

    window_timer #(.W(W)) u_window_timer (
        .clk        (clk),
        .rstn       (rstn),
        .load       (state == ST_CLEAR),
        .load_value (cycles_q),
        .en         (state == ST_RUN),
        .expire     (window_expire)
    );

    // Next-state and next sweep index; abort overrides every transition.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_next = (cycles_q == '0) ? ST_SWEEP : ST_RUN;
                idx_next   = '0;
            end
            ST_RUN: begin
                if (window_expire) state_next = ST_SWEEP;
                idx_next = '0;
            end
            ST_SWEEP: begin
                if (idx == LAST_IDX) begin
                    state_next = ST_DONE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
        if (abort) begin
            state_next = ST_IDLE;
            idx_next   = '0;
        end
    end

    // Shadow spin vector with the bit for the counter under the read port
    // folded in (strict unsigned compare: phase equal to threshold gives 0).
    always_comb begin
        shadow_next = shadow_q;
        if (state == ST_SWEEP) begin
            shadow_next[idx] = (phase > thresh_q);
        end
    end

    // FSM state, sweep index and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            idx         <= '0;
            sample_rstn <= 1'b1;
            rd_addr     <= PHASE_ADDR_BASE;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            sample_rstn <= (state_next != ST_CLEAR);
            rd_addr     <= (state_next == ST_SWEEP) ? sweep_addr(32'(idx_next))
                                                    : PHASE_ADDR_BASE;
            busy        <= (state_next == ST_CLEAR) || (state_next == ST_RUN) ||
                           (state_next == ST_SWEEP);
            done        <= (state_next == ST_DONE);
        end
    end

    // Run parameters are captured only when a start is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycles_q <= '0;
            thresh_q <= '0;
        end else if (start_ok) begin
            cycles_q <= sample_cycles;
            thresh_q <= threshold;
        end
    end

    // Spin capture: bits collect in the shadow during the sweep and are
    // published together on the edge that enters DONE; an aborted sweep
    // therefore never disturbs the previously published spins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_q     <= '0;
            spins        <= '0;
            result_valid <= 1'b0;
        end else begin
            if ((state == ST_SWEEP) && !abort) begin
                shadow_q <= shadow_next;
            end
            if (last_capture) begin
                spins        <= shadow_next;
                result_valid <= 1'b1;
            end else if (start_ok) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_phase_readout.sv
// Self-checking bench for phase_readout (N=3, W=32) with a behavioural
// phase sampler: phase is looked up combinationally from rd_addr.
// Timing reference: the start edge is offset 0; after it the block is in
// CLEAR, sweep index i is presented after offset 1+S+i and the done pulse is
// seen after offset 1+S+N (clock cycle t+2+S+N).
module tb_phase_readout;
    import phase_readout_pkg::*;

    localparam int N = 3;
    localparam int W = 32;

    logic         clk;
    logic         rstn;
    logic         start;
    logic         abort;
    logic [W-1:0] sample_cycles;
    logic [W-1:0] threshold;
    logic         sample_rstn;
    logic [31:0]  rd_addr;
    logic [W-1:0] phase;
    logic [N-1:0] spins;
    logic         result_valid;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] ph_mem [N];

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] thr;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] p2;
        logic [2:0]  exp_spins;
        logic        poke;
    } vec_t;

    vec_t vecs [6];

    phase_readout #(.N(N), .W(W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .abort         (abort),
        .sample_cycles (sample_cycles),
        .threshold     (threshold),
        .sample_rstn   (sample_rstn),
        .rd_addr       (rd_addr),
        .phase         (phase),
        .spins         (spins),
        .result_valid  (result_valid),
        .busy          (busy),
        .done          (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sampler read port.
    always_comb begin
        logic [31:0] off;
        phase = '0;
        off   = rd_addr - PHASE_ADDR_BASE;
        if ((off[1:0] == 2'b00) && ((off >> 2) < 32'(N))) phase = ph_mem[off >> 2];
    end

    // Watchdog: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [2:0] model_spins(input logic [31:0] thr,
                                               input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [31:0] c);
        logic [31:0] p [3];
        logic [2:0]  r;
        p[0] = a; p[1] = b; p[2] = c;
        r = '0;
        for (int i = 0; i < 3; i++) r[i] = (p[i] > thr);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One complete readout run, observed every cycle at the falling edge.
    task automatic do_run(input logic [31:0] s, input logic [31:0] thr,
                          input logic [31:0] p0, input logic [31:0] p1,
                          input logic [31:0] p2, input logic [2:0] exp_spins,
                          input logic poke, input string tag);
        int          done_exp, last_k, done_k, done_cnt, low_cnt, low_first;
        logic [31:0] addr_seen [3];
        logic [2:0]  spins_at_done;
        logic        rv_at_done;
        done_exp = 1 + int'(s) + N;
        last_k   = done_exp + 1;
        done_k = -1; done_cnt = 0; low_cnt = 0; low_first = -1;
        spins_at_done = 'x; rv_at_done = 1'bx;
        for (int i = 0; i < 3; i++) addr_seen[i] = 'x;
        ph_mem[0] = p0; ph_mem[1] = p1; ph_mem[2] = p2;
        sample_cycles = s;
        threshold     = thr;
        start         = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= last_k; k++) begin
            @(negedge clk);
            if (!sample_rstn) begin
                low_cnt++;
                if (low_first < 0) low_first = k;
            end
            if (k == 0) begin
                chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
                chk({tag, " result_valid_cleared"}, 32'(result_valid), 32'd0);
            end
            if ((k >= 1 + int'(s)) && (k < 1 + int'(s) + N)) addr_seen[k - 1 - int'(s)] = rd_addr;
            if (done) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k        = k;
                    spins_at_done = spins;
                    rv_at_done    = result_valid;
                end
            end
            start = (poke && ((k == 2) || (k == done_exp))) ? 1'b1 : 1'b0;
        end
        chk({tag, " sample_rstn_low_cycles"}, 32'(low_cnt), 32'd1);
        chk({tag, " sample_rstn_low_offset"}, 32'(low_first), 32'd0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s rd_addr_i%0d", tag, i), addr_seen[i], sweep_addr(32'(i)));
        chk({tag, " done_offset"}, 32'(done_k), 32'(done_exp));
        chk({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, " spins"}, 32'(spins_at_done), 32'(exp_spins));
        chk({tag, " result_valid"}, 32'(rv_at_done), 32'd1);
        chk({tag, " idle_after_done"}, 32'(busy), 32'd0);
        chk({tag, " spins_held"}, 32'(spins), 32'(exp_spins));
    endtask

    // Run aborted while the sweep is at index 1.
    task automatic do_abort_sweep(input logic [2:0] prev_spins);
        int done_cnt;
        done_cnt = 0;
        ph_mem[0] = 32'd0; ph_mem[1] = 32'd9; ph_mem[2] = 32'd9;
        sample_cycles = 32'd2;
        threshold     = 32'd5;
        start         = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) done_cnt++;
            if (k == 4) begin
                chk("abort rd_addr_at_i1", rd_addr, sweep_addr(32'd1));
                abort = 1'b1;
            end
        end
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort spins_kept", 32'(spins), 32'(prev_spins));
        chk("abort result_valid", 32'(result_valid), 32'd0);
        chk("abort sample_rstn", 32'(sample_rstn), 32'd1);
        chk("abort rd_addr_base", rd_addr, PHASE_ADDR_BASE);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort no_done_pulse", 32'(done_cnt), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " sample_rstn"}, 32'(sample_rstn), 32'd1);
        chk({tag, " rd_addr"}, rd_addr, PHASE_ADDR_BASE);
        chk({tag, " spins"}, 32'(spins), 32'd0);
        chk({tag, " result_valid"}, 32'(result_valid), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] s, thr;
        logic [31:0] p [3];
        int          bad;

        vecs[0] = '{s: 32'd10, thr: 32'd100, p0: 32'd150, p1: 32'd50, p2: 32'd101, exp_spins: 3'b101, poke: 1'b0};
        vecs[1] = '{s: 32'd0,  thr: 32'd100, p0: 32'd100, p1: 32'd100, p2: 32'd100, exp_spins: 3'b000, poke: 1'b0};
        vecs[2] = '{s: 32'd10, thr: 32'd100, p0: 32'd150, p1: 32'd50, p2: 32'd101, exp_spins: 3'b101, poke: 1'b1};
        vecs[3] = '{s: 32'd3,  thr: 32'd0,   p0: 32'd1,   p1: 32'd7,  p2: 32'd1,   exp_spins: 3'b111, poke: 1'b0};
        vecs[4] = '{s: 32'd1,  thr: 32'hFFFF_FFFF, p0: 32'hFFFF_FFFF, p1: 32'hFFFF_FFFE, p2: 32'd0,
                    exp_spins: 3'b000, poke: 1'b0};
        vecs[5] = '{s: 32'd2,  thr: 32'd99,  p0: 32'd100, p1: 32'd100, p2: 32'd99, exp_spins: 3'b011, poke: 1'b0};

        rstn = 1'b0; start = 1'b0; abort = 1'b0;
        sample_cycles = '0; threshold = '0;
        for (int i = 0; i < N; i++) ph_mem[i] = '0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort busy", 32'(busy), 32'd0);
        chk("start_abort sample_rstn", 32'(sample_rstn), 32'd1);
        @(negedge clk);

        // Directed table; entries 3..5 run back to back (start in the IDLE
        // cycle right after DONE).
        for (int v = 0; v < 6; v++)
            do_run(vecs[v].s, vecs[v].thr, vecs[v].p0, vecs[v].p1, vecs[v].p2,
                   vecs[v].exp_spins, vecs[v].poke, $sformatf("vec%0d", v));

        // Abort mid-sweep after a run left spins=3'b011.
        do_abort_sweep(3'b011);

        // Full-width window: no wrap, stays in RUN; then abort.
        sample_cycles = 32'hFFFF_FFFF; threshold = 32'd1; start = 1'b1;
        @(posedge clk);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k > 0 && (!busy || done || !sample_rstn || rd_addr != PHASE_ADDR_BASE)) bad++;
        end
        chk("long_window stays_in_run", 32'(bad), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("long_window abort_busy", 32'(busy), 32'd0);
        chk("long_window result_valid", 32'(result_valid), 32'd0);

        // Asynchronous reset mid-RUN.
        sample_cycles = 32'd10; threshold = 32'd3; start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rstn = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        do_run(32'd4, 32'd3, 32'd4, 32'd3, 32'd2, 3'b001, 1'b0, "after_reset");

        // Randomized runs against the reference model.
        for (int r = 0; r < 12; r++) begin
            s   = 32'($urandom_range(0, 12));
            thr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            for (int i = 0; i < 3; i++) begin
                case ($urandom_range(0, 3))
                    0: p[i] = thr - 32'd1;
                    1: p[i] = thr;
                    2: p[i] = thr + 32'd1;
                    default: p[i] = $urandom;
                endcase
            end
            do_run(s, thr, p[0], p[1], p[2], model_spins(thr, p[0], p[1], p[2]),
                   1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
